fir_line_buf_ctrl: RTL and testbench
====================================

Name: fir_line_buf_ctrl

Overview:
- Sequencer for the 2D FIR filter's line buffers.
- Tracks column and row position from the dv_i/hs_i/vs_i video timing.
- Rotates three dual-port BRAM row banks: one bank is written with the current row while the other two are read as rows m-1 and m-2.
- Sits between the video input timing and the BRAM/convolution datapath, and tells the convolution stage when a full 3-row window is available.

Parameters:
- MAX_COLS, 1600, maximum active pixels per line (BRAM depth).
- MAX_ROWS, 900, maximum active lines per frame.
- COL_W, 11, width of the column counter and BRAM addresses.
- ROW_W, 10, width of the row counter.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- dv_i  in  1  data valid; high during active pixels of a line.
- hs_i  in  1  horizontal sync (level).
- vs_i  in  1  vertical sync (level); a rising edge starts a frame.
- wr_en_o  out  3  one-hot write enable to banks 0..2.
- wr_addr_o  out  COL_W  write address (column of the pixel being stored).
- rd_addr_o  out  COL_W  read address applied to both read banks.
- sel_m1_o  out  2  index of the bank holding row m-1.
- sel_m2_o  out  2  index of the bank holding row m-2.
- col_o  out  COL_W  column of the current pixel.
- row_o  out  ROW_W  row of the current pixel.
- win_valid_o  out  1  3-row window valid for this pixel.
- line_end_o  out  1  single-cycle pulse when a line completes.
- ovf_err_o  out  1  sticky overflow flag.

Behaviour:
- Edge detection:
  - Registered copies vs_q and dv_q.
  - vs_rise = vs_i & ~vs_q.
  - dv_fall = dv_q & ~dv_i.
- States:
  - S_IDLE: entered on reset. Ignores dv_i until the first vs_rise.
  - S_BLANK: waiting for dv_i.
  - S_ACTIVE: dv_i high.
- Transitions:
  - IDLE -> BLANK on vs_rise.
  - BLANK -> ACTIVE on dv_i (if vs_rise is not present in the same cycle).
  - ACTIVE -> BLANK on dv_fall.
  - Any state -> BLANK on vs_rise.
- Frame start (vs_rise):
  - col=0, row=0, wr_bank=0, sel_m1=2, sel_m2=1.
  - vs_rise has priority. A dv_i pixel in the same cycle is dropped (no write, counters not advanced).
- Pixel (state BLANK or ACTIVE, dv_i=1, no vs_rise), outputs registered with 1-cycle latency:
  - wr_en_o = one-hot(wr_bank).
  - wr_addr_o = rd_addr_o = col.
  - col_o = col, row_o = row.
  - win_valid_o = (row >= 2).
  - col then increments.
- When no pixel is written in a cycle: wr_en_o = 0. Address outputs hold their last value.
- Line end (dv_fall in ACTIVE):
  - line_end_o pulses 1 cycle, aligned with the cycle after the last pixel's outputs.
  - col <= 0.
  - row <= row+1, saturating at MAX_ROWS-1.
  - sel_m2 <= sel_m1, sel_m1 <= wr_bank, wr_bank <= (wr_bank+1) mod 3.
  - The three bank indices are always a permutation of {0,1,2}.
- hs_i is for alignment only: no counter action. An hs_i rising edge while in ACTIVE is treated as a line end (same actions as dv_fall) and sets ovf_err_o.
- Column overflow: a pixel arriving with col == MAX_COLS:
  - Write suppressed (wr_en_o=0), win_valid_o=0.
  - col holds at MAX_COLS, ovf_err_o set.
- Row overflow: a line end at row == MAX_ROWS-1 sets ovf_err_o.
- ovf_err_o clears only on rst or vs_rise.
- Reset values (all outputs, asynchronous):
  - wr_en_o=0, wr_addr_o=0, rd_addr_o=0.
  - sel_m1_o=2, sel_m2_o=1.
  - col_o=0, row_o=0.
  - win_valid_o=0, line_end_o=0, ovf_err_o=0.
  - state = S_IDLE.
- Reset asserted mid-line: all outputs return to reset values immediately. The block stays in IDLE until the next vs_rise, even if dv_i remains high.
- Read/write same address: the read banks never equal the write bank, so there is no port conflict.

Test Plan:
1. MAX_COLS=8, MAX_ROWS=6; vs pulse, then 3 lines of 8 dv_i pixels with 4 blank cycles between lines:
   - wr_en_o = 001, 010, 100 per line.
   - wr_addr_o steps 0..7 each line.
   - line_end_o pulses 3 times.
   - win_valid_o high only on row 2, cols 0..7.
2. Same frame, check bank indices after each line end:
   - (wr, m1, m2) = (1,0,2), (2,1,0), (0,2,1).
   - wr_en_o one-hot never matches sel_m1_o or sel_m2_o.
3. Line of 10 pixels with MAX_COLS=8:
   - Writes at addresses 0..7 only.
   - ovf_err_o rises on the 9th pixel and stays high until the next vs_rise.
4. vs_rise coincident with dv_i=1:
   - No write that cycle.
   - The next pixel is written at col 0, row 0, bank 0; ovf_err_o cleared.
5. rst asserted at col 4 of row 3 while dv_i stays high:
   - Outputs go to reset values in the same cycle.
   - No wr_en_o until vs_rise; the first write after that is bank 0, address 0.
6. dv_i pulses before any vs_i after reset:
   - wr_en_o stays 0, state remains IDLE, row_o=0.

Source files
------------

// File: rtl/fir_line_buf_ctrl.sv
// Line-buffer sequencer for the 2D FIR: tracks pixel position from video timing and
// rotates three BRAM row banks (one written, two read as rows m-1 / m-2). Outputs are registered, one cycle after the input pixel.
module fir_line_buf_ctrl #(
    parameter int MAX_COLS = 1600,
    parameter int MAX_ROWS = 900,
    parameter int COL_W    = 11,
    parameter int ROW_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dv_i,
    input  logic             hs_i,
    input  logic             vs_i,
    output logic [2:0]       wr_en_o,
    output logic [COL_W-1:0] wr_addr_o,
    output logic [COL_W-1:0] rd_addr_o,
    output logic [1:0]       sel_m1_o,
    output logic [1:0]       sel_m2_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             win_valid_o,
    output logic             line_end_o,
    output logic             ovf_err_o
);

    localparam logic [COL_W-1:0] COL_LIM  = COL_W'(MAX_COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAX_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ACTIVE} state_t;

    state_t           state;
    logic             vs_q, dv_q, hs_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [1:0]       wr_bank;

    logic vs_rise, dv_fall, hs_rise, pixel, line_end, col_full;

    assign vs_rise  = vs_i & ~vs_q;
    assign dv_fall  = dv_q & ~dv_i;
    assign hs_rise  = hs_i & ~hs_q;
    // Frame start wins over a coincident pixel, which is simply dropped.
    assign pixel    = (state != S_IDLE) && dv_i && !vs_rise;
    assign line_end = (state == S_ACTIVE) && (dv_fall || hs_rise) && !vs_rise;
    assign col_full = (col == COL_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            vs_q        <= 1'b0;
            dv_q        <= 1'b0;
            hs_q        <= 1'b0;
            col         <= '0;
            row         <= '0;
            wr_bank     <= 2'd0;
            wr_en_o     <= 3'b000;
            wr_addr_o   <= '0;
            rd_addr_o   <= '0;
            sel_m1_o    <= 2'd2;
            sel_m2_o    <= 2'd1;
            col_o       <= '0;
            row_o       <= '0;
            win_valid_o <= 1'b0;
            line_end_o  <= 1'b0;
            ovf_err_o   <= 1'b0;
        end else begin
            vs_q        <= vs_i;
            dv_q        <= dv_i;
            hs_q        <= hs_i;
            wr_en_o     <= 3'b000;
            win_valid_o <= 1'b0;
            line_end_o  <= 1'b0;

            if (vs_rise) begin
                state     <= S_BLANK;
                col       <= '0;
                row       <= '0;
                wr_bank   <= 2'd0;
                sel_m1_o  <= 2'd2;
                sel_m2_o  <= 2'd1;
                ovf_err_o <= 1'b0;
            end else begin
                if (pixel) begin
                    col_o <= col;
                    row_o <= row;
                    if (col_full) begin
                        ovf_err_o <= 1'b1;
                    end else begin
                        wr_en_o     <= 3'b001 << wr_bank;
                        wr_addr_o   <= col;
                        rd_addr_o   <= col;
                        win_valid_o <= (row >= ROW_W'(2));
                        col         <= col + COL_W'(1);
                    end
                end

                // A line end overrides the column increment of a same-cycle pixel.
                if (line_end) begin
                    line_end_o <= 1'b1;
                    col        <= '0;
                    if (row == ROW_LAST)
                        ovf_err_o <= 1'b1;
                    else
                        row <= row + ROW_W'(1);
                    if (hs_rise)
                        ovf_err_o <= 1'b1;
                    sel_m2_o <= sel_m1_o;
                    sel_m1_o <= wr_bank;
                    wr_bank  <= (wr_bank == 2'd2) ? 2'd0 : wr_bank + 2'd1;
                end

                case (state)
                    S_IDLE:   state <= S_IDLE;
                    S_BLANK:  if (dv_i) state <= S_ACTIVE;
                    S_ACTIVE: if (line_end) state <= S_BLANK;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_line_buf_ctrl.sv
// Scoreboard bench for fir_line_buf_ctrl with an 8-column, 6-row frame geometry.
module tb_fir_line_buf_ctrl;

    localparam int MAX_COLS = 8;
    localparam int MAX_ROWS = 6;
    localparam int COL_W    = 11;
    localparam int ROW_W    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             dv_i, hs_i, vs_i;
    logic [2:0]       wr_en_o;
    logic [COL_W-1:0] wr_addr_o, rd_addr_o, col_o;
    logic [1:0]       sel_m1_o, sel_m2_o;
    logic [ROW_W-1:0] row_o;
    logic             win_valid_o, line_end_o, ovf_err_o;

    fir_line_buf_ctrl #(
        .MAX_COLS(MAX_COLS), .MAX_ROWS(MAX_ROWS), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .clk(clk), .rst(rst), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .rd_addr_o(rd_addr_o),
        .sel_m1_o(sel_m1_o), .sel_m2_o(sel_m2_o), .col_o(col_o), .row_o(row_o),
        .win_valid_o(win_valid_o), .line_end_o(line_end_o), .ovf_err_o(ovf_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  en;
        int          addr;
        int          row;
        logic        win;
    } wr_exp_t;

    wr_exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int le_cnt = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic push(input int bank, input int addr, input int row);
        wr_exp_t e;
        logic [2:0] one;
        one    = 3'b001;
        e.en   = one << bank;
        e.addr = addr;
        e.row  = row;
        e.win  = (row >= 2);
        q.push_back(e);
    endtask

    task automatic cyc(input logic d, input logic h, input logic v);
        dv_i = d;
        hs_i = h;
        vs_i = v;
        @(posedge clk);
        #1;
    endtask

    // One full line (pixels beyond MAX_COLS expect no write), then blanking with an hs pulse.
    task automatic line(input int l, input int n);
        for (int c = 0; c < n; c++) begin
            if (c < MAX_COLS) push(l % 3, c, l);
            cyc(1'b1, 1'b0, 1'b0);
            if (c == MAX_COLS - 1) chk("ovf_low", ovf_err_o, 0);
            if (c == MAX_COLS)     chk("ovf_rise", ovf_err_o, 1);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("sel_m1", sel_m1_o, l % 3);
        chk("sel_m2", sel_m2_o, (l + 2) % 3);
        chk("q_drained", q.size(), 0);
    endtask

    always @(negedge clk) begin
        wr_exp_t e;
        if (line_end_o) le_cnt++;
        if (wr_en_o != 3'b000) begin
            chk("wr_m1_clash", int'(wr_en_o & (3'b001 << sel_m1_o)), 0);
            chk("wr_m2_clash", int'(wr_en_o & (3'b001 << sel_m2_o)), 0);
            if (q.size() == 0) begin
                chk("spurious_wr", int'(wr_en_o), 0);
            end else begin
                e = q.pop_front();
                chk("wr_en", int'(wr_en_o), int'(e.en));
                chk("wr_addr", int'(wr_addr_o), e.addr);
                chk("rd_addr", int'(rd_addr_o), e.addr);
                chk("col", int'(col_o), e.addr);
                chk("row", int'(row_o), e.row);
                chk("win_valid", int'(win_valid_o), int'(e.win));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        dv_i = 1'b0;
        hs_i = 1'b0;
        vs_i = 1'b0;
        #3;
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_sel_m1", sel_m1_o, 2);
        chk("rst_sel_m2", sel_m2_o, 1);
        chk("rst_row", row_o, 0);
        chk("rst_ovf", ovf_err_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pixels before any frame start are ignored.
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("idle_row", row_o, 0);
        chk("idle_le", le_cnt, 0);

        // Frame with three full lines, then an overlong line.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        line(0, 8);
        line(1, 8);
        line(2, 8);
        chk("le_count", le_cnt, 3);
        line(3, 10);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", ovf_err_o, 1);

        // Frame start coincident with a pixel: that pixel is dropped.
        cyc(1'b1, 1'b0, 1'b1);
        chk("vs_ovf_clr", ovf_err_o, 0);
        chk("vs_no_wr", wr_en_o, 0);
        push(0, 0, 0);
        cyc(1'b1, 1'b0, 1'b1);
        push(0, 1, 0);
        cyc(1'b1, 1'b0, 1'b0);
        push(0, 2, 0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        chk("short_m1", sel_m1_o, 0);
        line(1, 8);
        line(2, 8);

        // Reset at column 4 of row 3 with dv still high.
        for (int c = 0; c < 4; c++) begin
            push(0, c, 3);
            cyc(1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_wr_en", wr_en_o, 0);
        chk("mid_wr_addr", wr_addr_o, 0);
        chk("mid_rd_addr", rd_addr_o, 0);
        chk("mid_col", col_o, 0);
        chk("mid_row", row_o, 0);
        chk("mid_sel_m1", sel_m1_o, 2);
        chk("mid_sel_m2", sel_m2_o, 1);
        chk("mid_win", win_valid_o, 0);
        chk("mid_le", line_end_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_row", row_o, 0);
        chk("post_rst_q", q.size(), 0);
        cyc(1'b0, 1'b0, 1'b1);
        push(0, 0, 0);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        chk("final_q", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
